inout_pair_seq: RTL and testbench

Address sequencer and pair unpacker that sits directly upstream of the 128 × 24-bit in/out index ROM in the Kyber NTT data-in path. On `start` it sweeps the ROM address 0..127 and absorbs the ROM's one-cycle read latency. It splits each returned word into two 8-bit coefficient indices plus an 8-bit tag. It delivers them as a valid/ready pair stream to the coefficient loader, with no loss or duplication under backpressure.

---
 rtl/inout_pkg.sv | 34 +++
 rtl/pair_fifo2.sv | 51 +++++
 rtl/inout_pair_seq.sv | 121 ++++++++++++
 tb/tb_inout_pair_seq.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inout_pkg.sv
// Shared constants and record types for the Kyber NTT in/out index ROM sequencer.
package inout_pkg;

    localparam int unsigned PAIRS  = 128;
    localparam int unsigned ADDR_W = 9;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned NUM_W  = 7;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0] idx_a;
        logic [IDX_W-1:0] idx_b;
        logic [IDX_W-1:0] tag;
        logic [NUM_W-1:0] num;
    } pair_t;

    function automatic pair_t split_word(
        input logic [3*IDX_W-1:0] word,
        input logic [NUM_W-1:0]   num
    );
        pair_t rec;
        rec.idx_a = word[3*IDX_W-1:2*IDX_W];
        rec.idx_b = word[2*IDX_W-1:IDX_W];
        rec.tag   = word[IDX_W-1:0];
        rec.num   = num;
        return rec;
    endfunction

endpackage

// File: rtl/pair_fifo2.sv
// Two-entry FIFO holding every pair record presented on the output stream.
module pair_fifo2
    import inout_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_i,
    input  logic       pop_i,
    input  pair_t      din_i,
    output pair_t      head_o,
    output logic [1:0] count_o
);

    pair_t      mem_q [2];
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
        if (push_i) begin
            wr_d = ~wr_q;
        end
        if (pop_i) begin
            rd_d = ~rd_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
            end
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/inout_pair_seq.sv
// Sweeps the in/out index ROM, absorbs its read latency and streams the
// unpacked index pairs to the coefficient loader under valid/ready.
module inout_pair_seq #(
    parameter int unsigned PAIRS  = inout_pkg::PAIRS,
    parameter int unsigned ADDR_W = inout_pkg::ADDR_W,
    parameter int unsigned IDX_W  = inout_pkg::IDX_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [3*IDX_W-1:0] rom_data,
    output logic               pair_valid,
    input  logic               pair_ready,
    output logic [IDX_W-1:0]   pair_idx_a,
    output logic [IDX_W-1:0]   pair_idx_b,
    output logic [IDX_W-1:0]   pair_tag,
    output logic [6:0]         pair_num,
    output logic               pair_last
);

    import inout_pkg::*;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] issued_q, issued_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              inflight_q, inflight_d;
    logic              done_q, done_d;

    pair_t      fifo_head;
    pair_t      push_rec;
    logic [1:0] fifo_count;
    logic       fifo_valid;
    logic       pop;
    logic       credit_ok;
    logic       issue;
    logic       last_pop;

    assign fifo_valid = (fifo_count != 2'd0);
    assign pop        = fifo_valid & pair_ready;

    // Occupancy after this edge (FIFO plus the word still in flight) must stay below two.
    assign credit_ok  = ({1'b0, fifo_count} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop});
    assign issue      = (state_q == RUN) && (issued_q < ADDR_W'(PAIRS)) && credit_ok;
    assign last_pop   = pop && (fifo_head.num == NUM_W'(PAIRS - 1));

    // rom_addr_q still holds the address whose word is on rom_data this cycle.
    assign push_rec   = split_word(rom_data, rom_addr_q[NUM_W-1:0]);

    always_comb begin
        state_d    = state_q;
        issued_d   = issued_q;
        rom_addr_d = rom_addr_q;
        inflight_d = issue;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    issued_d   = '0;
                    rom_addr_d = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    rom_addr_d = issued_q;
                    issued_d   = issued_q + ADDR_W'(1);
                    if (issued_q == ADDR_W'(PAIRS - 1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (last_pop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            issued_q   <= '0;
            rom_addr_q <= '0;
            inflight_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            issued_q   <= issued_d;
            rom_addr_q <= rom_addr_d;
            inflight_q <= inflight_d;
            done_q     <= done_d;
        end
    end

    pair_fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .pop_i   (pop),
        .din_i   (push_rec),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign rom_addr   = rom_addr_q;
    assign pair_valid = fifo_valid;
    assign pair_idx_a = fifo_head.idx_a;
    assign pair_idx_b = fifo_head.idx_b;
    assign pair_tag   = fifo_head.tag;
    assign pair_num   = fifo_head.num;
    assign pair_last  = fifo_valid && (fifo_head.num == NUM_W'(PAIRS - 1));

endmodule

// File: tb/tb_inout_pair_seq.sv
// Bench for inout_pair_seq: ROM model, handshake monitor and per-scenario tasks.
`timescale 1ns/1ps
module tb_inout_pair_seq;

    localparam int PAIRS = 128;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic [8:0] rom_addr;
    logic [23:0] rom_data;
    logic       pair_valid;
    logic       pair_ready;
    logic [7:0] pair_idx_a;
    logic [7:0] pair_idx_b;
    logic [7:0] pair_tag;
    logic [6:0] pair_num;
    logic       pair_last;

    logic [23:0] rom_mem [PAIRS];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] t;
        logic [6:0] n;
        logic       l;
        int         e;
    } beat_t;

    beat_t got[$];
    int    cyc       = 0;
    int    done_cnt  = 0;
    int    done_e    = -1;
    int    busy_fall = -1;
    int    max_cnt   = 0;
    logic  prev_busy = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // ROM address register lives in the DUT; the array read is the ROM's output stage.
    always_comb rom_data = rom_mem[rom_addr[6:0]];

    inout_pair_seq #(
        .PAIRS  (128),
        .ADDR_W (9),
        .IDX_W  (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .pair_valid (pair_valid),
        .pair_ready (pair_ready),
        .pair_idx_a (pair_idx_a),
        .pair_idx_b (pair_idx_b),
        .pair_tag   (pair_tag),
        .pair_num   (pair_num),
        .pair_last  (pair_last)
    );

    always @(posedge clk) cyc++;

    // A beat seen valid&ready here handshakes on the next rising edge.
    always @(negedge clk) begin
        beat_t bt;
        if (pair_valid === 1'b1 && pair_ready === 1'b1) begin
            bt.a = pair_idx_a;
            bt.b = pair_idx_b;
            bt.t = pair_tag;
            bt.n = pair_num;
            bt.l = pair_last;
            bt.e = cyc + 1;
            got.push_back(bt);
        end
        if (done === 1'b1) begin
            done_cnt++;
            done_e = cyc;
        end
        if (prev_busy === 1'b1 && busy === 1'b0) busy_fall = cyc;
        prev_busy = busy;
        if (int'(dut.u_fifo.count_o) > max_cnt) max_cnt = int'(dut.u_fifo.count_o);
    end

    initial begin
        #400us;
        $display("FAIL watchdog: simulation time limit reached, got=%0d done_cnt=%0d", got.size(), done_cnt);
        $fatal(1, "watchdog");
    end

    // Reference: beat k carries ROM entry k split into three bytes, in order.
    function automatic int first_bad();
        for (int k = 0; k < got.size() && k < PAIRS; k++) begin
            logic [23:0] w;
            w = rom_mem[k];
            if (got[k].a !== w[23:16] || got[k].b !== w[15:8] || got[k].t !== w[7:0] ||
                got[k].n !== 7'(k) || got[k].l !== (k == PAIRS - 1))
                return k;
        end
        return -1;
    endfunction

    task automatic load_linear();
        for (int i = 0; i < PAIRS; i++) rom_mem[i] = {8'(2 * i), 8'(2 * i + 1), 8'h00};
    endtask

    task automatic pulse_start(output int e0);
        @(posedge clk); #2 start = 1'b1;
        @(posedge clk); #1 e0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (done_cnt >= target);
    endtask

    task automatic wait_beats(input int target, input int budget, output bit ok);
        int n = 0;
        while (got.size() < target && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        ok = (got.size() >= target);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; pair_ready = 1'b0;
        load_linear();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({busy, done, rom_addr, pair_valid, pair_idx_a, pair_idx_b, pair_tag, pair_num, pair_last} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b done=%b addr=%0d valid=%b a=%0d b=%0d tag=%0d num=%0d last=%b, required all zero",
                     busy, done, rom_addr, pair_valid, pair_idx_a, pair_idx_b, pair_tag, pair_num, pair_last);
        end
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || pair_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: busy=%b valid=%b, required 0 0", busy, pair_valid);
        end
    endtask

    task automatic test_full_run();
        int e0, bad, base;
        bit ok;
        got.delete(); base = done_cnt; load_linear(); pair_ready = 1'b1;
        pulse_start(e0);
        n_checks++;
        if (busy !== 1'b1 || rom_addr !== 9'd0) begin
            n_fail++;
            $display("FAIL start_edge: busy=%b rom_addr=%0d, required 1 and 0", busy, rom_addr);
        end
        wait_done(base + 1, 400, ok);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (!ok || got.size() != PAIRS) begin
            n_fail++;
            $display("FAIL full_count: %0d handshakes (done seen=%0b), required %0d", got.size(), ok, PAIRS);
        end
        bad = first_bad();
        n_checks++;
        if (bad != -1) begin
            n_fail++;
            $display("FAIL full_data: beat %0d = (%0d,%0d,%0d,num %0d,last %b), required ROM entry %0d", bad,
                     got[bad].a, got[bad].b, got[bad].t, got[bad].n, got[bad].l, bad);
        end
        for (int k = 0; k < got.size(); k++) begin
            n_checks++;
            if (got[k].e != e0 + 3 + k) begin
                n_fail++;
                $display("FAIL full_timing: beat %0d handshake at E%0d, required E%0d", k, got[k].e - e0, 3 + k);
            end
        end
        n_checks++;
        if (done_cnt - base != 1 || done_e != e0 + 130) begin
            n_fail++;
            $display("FAIL full_done: %0d pulses at E%0d, required 1 at E130", done_cnt - base, done_e - e0);
        end
        n_checks++;
        if (busy_fall != e0 + 130) begin
            n_fail++;
            $display("FAIL full_busy: busy fell at E%0d, required E130", busy_fall - e0);
        end
    endtask

    task automatic test_stall();
        int e0, bad, base, addr0;
        bit ok;
        got.delete(); base = done_cnt; load_linear(); pair_ready = 1'b1; max_cnt = 0;
        pulse_start(e0);
        wait_beats(5, 100, ok);
        pair_ready = 1'b0;
        addr0 = int'(rom_addr);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if (pair_valid !== 1'b1 || pair_idx_a !== 8'd10 || pair_idx_b !== 8'd11 ||
                pair_tag !== 8'd0 || pair_num !== 7'd5 || pair_last !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold: cycle %0d valid=%b a=%0d b=%0d tag=%0d num=%0d, required 1 10 11 0 5",
                         i, pair_valid, pair_idx_a, pair_idx_b, pair_tag, pair_num);
            end
        end
        n_checks++;
        if (int'(rom_addr) - addr0 > 1 || int'(rom_addr) < addr0) begin
            n_fail++;
            $display("FAIL stall_issue: rom_addr moved %0d -> %0d during stall, required at most one step", addr0, rom_addr);
        end
        #1 pair_ready = 1'b1;
        wait_done(base + 1, 400, ok);
        repeat (3) @(posedge clk);
        bad = first_bad();
        n_checks++;
        if (!ok || got.size() != PAIRS || bad != -1) begin
            n_fail++;
            $display("FAIL stall_sequence: %0d beats, first bad %0d, required 128 in order", got.size(), bad);
        end
        n_checks++;
        if (max_cnt > 2 || done_cnt - base != 1) begin
            n_fail++;
            $display("FAIL stall_fifo: max fifo count %0d, done pulses %0d, required <=2 and 1", max_cnt, done_cnt - base);
        end
    endtask

    task automatic run_random_ready(input int base, output bit ok);
        logic       pv, pr;
        logic [30:0] snap;
        int n = 0;
        pv = 1'b0; pr = 1'b1; snap = '0;
        while (done_cnt < base + 1 && n < 3000) begin
            @(posedge clk); #1;
            if (pv === 1'b1 && pr === 1'b0) begin
                n_checks++;
                if (pair_valid !== 1'b1 || {pair_idx_a, pair_idx_b, pair_tag, pair_num} !== snap) begin
                    n_fail++;
                    $display("FAIL rand_hold: valid=%b fields=%h, required 1 and %h", pair_valid,
                             {pair_idx_a, pair_idx_b, pair_tag, pair_num}, snap);
                end
            end
            #1 pair_ready = ($urandom_range(0, 1) == 1);
            pv = pair_valid; pr = pair_ready;
            snap = {pair_idx_a, pair_idx_b, pair_tag, pair_num};
            n++;
        end
        pair_ready = 1'b1;
        ok = (done_cnt >= base + 1);
    endtask

    task automatic test_random_ready();
        int e0, bad, base;
        bit ok;
        got.delete(); base = done_cnt; load_linear(); pair_ready = 1'b1; max_cnt = 0;
        void'($urandom(32'h5eed));
        pulse_start(e0);
        run_random_ready(base, ok);
        repeat (5) @(posedge clk);
        bad = first_bad();
        n_checks++;
        if (!ok || got.size() != PAIRS || bad != -1) begin
            n_fail++;
            $display("FAIL rand_sequence: %0d beats, first bad %0d, required 128 in order", got.size(), bad);
        end
        n_checks++;
        if (max_cnt > 2 || done_cnt - base != 1) begin
            n_fail++;
            $display("FAIL rand_fifo: max fifo count %0d, done pulses %0d, required <=2 and 1", max_cnt, done_cnt - base);
        end
    endtask

    task automatic test_start_ignored();
        int e0, bad, base;
        bit ok;
        got.delete(); base = done_cnt; load_linear(); pair_ready = 1'b1;
        pulse_start(e0);
        wait_beats(40, 100, ok);
        start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        wait_beats(127, 200, ok);
        start = 1'b1;
        @(posedge clk); #2 start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        bad = first_bad();
        n_checks++;
        if (got.size() != PAIRS || bad != -1) begin
            n_fail++;
            $display("FAIL start_ign_sequence: %0d beats, first bad %0d, required 128 in order", got.size(), bad);
        end
        n_checks++;
        if (done_cnt - base != 1 || busy !== 1'b0 || pair_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_ign_state: done pulses %0d busy=%b valid=%b, required 1 0 0", done_cnt - base, busy, pair_valid);
        end
    endtask

    task automatic test_async_reset();
        int e0, bad, base;
        bit ok;
        got.delete(); load_linear(); pair_ready = 1'b1;
        pulse_start(e0);
        wait_beats(60, 150, ok);
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, rom_addr, pair_valid, pair_idx_a, pair_idx_b, pair_tag, pair_num, pair_last} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: busy=%b addr=%0d valid=%b a=%0d b=%0d num=%0d, required all zero",
                     busy, rom_addr, pair_valid, pair_idx_a, pair_idx_b, pair_num);
        end
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        got.delete(); base = done_cnt;
        pulse_start(e0);
        wait_done(base + 1, 400, ok);
        repeat (3) @(posedge clk);
        n_checks++;
        if (got.size() == 0 || got[0].a !== 8'd0 || got[0].b !== 8'd1 || got[0].n !== 7'd0) begin
            n_fail++;
            if (got.size() == 0) $display("FAIL restart_first: no beats, required (0,1,num 0)");
            else $display("FAIL restart_first: (%0d,%0d,num %0d), required (0,1,num 0)", got[0].a, got[0].b, got[0].n);
        end
        bad = first_bad();
        n_checks++;
        if (!ok || got.size() != PAIRS || bad != -1) begin
            n_fail++;
            $display("FAIL restart_sequence: %0d beats, first bad %0d, required 128 in order", got.size(), bad);
        end
    endtask

    task automatic test_tag_passthrough();
        int e0, bad, base, hits, hit_num;
        bit ok;
        got.delete(); base = done_cnt; pair_ready = 1'b1; max_cnt = 0;
        for (int i = 0; i < PAIRS; i++) rom_mem[i] = {8'($urandom), 8'($urandom), 8'h00};
        rom_mem[17][7:0] = 8'hA5;
        pulse_start(e0);
        run_random_ready(base, ok);
        repeat (5) @(posedge clk);
        bad = first_bad();
        n_checks++;
        if (!ok || got.size() != PAIRS || bad != -1) begin
            n_fail++;
            $display("FAIL tag_sequence: %0d beats, first bad %0d, required 128 matching ROM", got.size(), bad);
        end
        hits = 0; hit_num = -1;
        foreach (got[k]) begin
            if (got[k].t == 8'hA5) begin
                hits++;
                hit_num = int'(got[k].n);
            end
        end
        n_checks++;
        if (hits != 1 || hit_num != 17) begin
            n_fail++;
            $display("FAIL tag_a5: %0d beats carry A5 (last num %0d), required exactly beat 17", hits, hit_num);
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_stall();
        test_random_ready();
        test_start_ignored();
        test_async_reset();
        test_tag_passthrough();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
